// File: rtl/clock_controller_pkg.sv
// clock_controller_pkg
//   Shared constants for the clock-enable generator: operating-mode encodings
//   and the default parameter values used by clock_controller and
//   button_debouncer.
//   Ports: none (package).
package clock_controller_pkg;

   // mode input encoding; 2'd3 is not named and behaves as halt
   localparam logic [1:0] MODE_HALT = 2'd0;
   localparam logic [1:0] MODE_RUN  = 2'd1;
   localparam logic [1:0] MODE_STEP = 2'd2;

   // 1 Hz tick at 50 MHz, and a 10 ms button stability window
   localparam int CC_DEFAULT_DIV     = 50000000;
   localparam int CC_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
//   Brings the raw step push-button into the clock50MHZ domain and turns each
//   press into a single-cycle pulse.
//   Optional feature macro: CLOCK_CONTROLLER_DEBOUNCE_EN
//     defined   : the synchronised level must hold DEBOUNCE_CYCLES consecutive
//                 samples before the filtered level follows it.
//     undefined : the synchronised level is used directly.
//   Ports:
//     clock50MHZ  in   board clock
//     reset_n     in   asynchronous active-low reset
//     button      in   raw asynchronous button, active-high
//     rise        out  one-cycle pulse on each (filtered) rising edge, combinational
//                      from registered state
module button_debouncer
   import clock_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = CC_DEBOUNCE_CYCLES
) (
   input  logic clock50MHZ,
   input  logic reset_n,
   input  logic button,
   output logic rise
);

   logic [1:0] sync;
   logic       level;
   logic       level_q;

   always_ff @(posedge clock50MHZ or negedge reset_n) begin
      if (!reset_n) sync <= 2'b00;
      else          sync <= {sync[0], button};
   end

`ifdef CLOCK_CONTROLLER_DEBOUNCE_EN
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CNT_W-1:0] stable_cnt;
   logic             filt;

   // stable_cnt counts consecutive samples that disagree with the filtered
   // level; any agreeing sample restarts the window, so glitches vanish.
   always_ff @(posedge clock50MHZ or negedge reset_n) begin
      if (!reset_n) begin
         filt       <= 1'b0;
         stable_cnt <= '0;
      end else if (sync[1] == filt) begin
         stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         filt       <= sync[1];
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt + 1'b1;
      end
   end

   assign level = filt;
`else
   assign level = sync[1];
`endif

   always_ff @(posedge clock50MHZ or negedge reset_n) begin
      if (!reset_n) level_q <= 1'b0;
      else          level_q <= level;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/clock_controller.sv
// clock_controller
//   CHANNELS independent programmable tick generators in the clock50MHZ
//   domain, with halt and single-step modes. Outputs are one-cycle enables,
//   never clocks.
//   Optional feature macro: CLOCK_CONTROLLER_DEBOUNCE_EN (step button filter,
//   see button_debouncer).
//   Ports:
//     clock50MHZ   in   board clock, the only clock
//     reset_n      in   asynchronous active-low reset
//     mode         in   0 halt, 1 run, 2 step, 3 halt
//     step_button  in   raw button, active-high
//     cfg_wen      in   divisor write strobe
//     cfg_channel  in   channel addressed by the write (out-of-range ignored)
//     cfg_divisor  in   new divisor (0 behaves as 1)
//     tick         out  per-channel one-cycle enable, registered
//     running      out  registered, high while mode is run
//     step_count   out  steps issued, wraps
module clock_controller
   import clock_controller_pkg::*;
#(
   parameter int   CHANNELS        = 2,
   parameter int   DIV_W           = 26,
   parameter int   DEFAULT_DIV     = CC_DEFAULT_DIV,
   parameter int   DEBOUNCE_CYCLES = CC_DEBOUNCE_CYCLES,
   localparam int  CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock50MHZ,
   input  logic                reset_n,
   input  logic [1:0]          mode,
   input  logic                step_button,
   input  logic                cfg_wen,
   input  logic [CH_W-1:0]     cfg_channel,
   input  logic [DIV_W-1:0]    cfg_divisor,
   output logic [CHANNELS-1:0] tick,
   output logic                running,
   output logic [31:0]         step_count
);

   logic [CHANNELS-1:0][DIV_W-1:0] cnt;
   logic [CHANNELS-1:0][DIV_W-1:0] div;
   logic [CHANNELS-1:0][DIV_W-1:0] last;
   logic [CHANNELS-1:0]            term;
   logic [CHANNELS-1:0]            wr_hit;
   logic                           step_rise;
   logic                           step_fire;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clock50MHZ (clock50MHZ),
      .reset_n    (reset_n),
      .button     (step_button),
      .rise       (step_rise)
   );

   // presses outside step mode are dropped, not queued
   assign step_fire = (mode == MODE_STEP) && step_rise;

   always_comb begin
      last   = '0;
      term   = '0;
      wr_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         // terminal count is eff-1 with eff = max(div,1)
         last[i]   = (div[i] == '0) ? '0 : div[i] - 1'b1;
         term[i]   = (cnt[i] == last[i]);
         // indices >= CHANNELS never match, so those writes fall away
         wr_hit[i] = cfg_wen && (cfg_channel == CH_W'(i));
      end
   end

   always_ff @(posedge clock50MHZ or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         tick       <= '0;
         running    <= 1'b0;
         step_count <= '0;
         for (int i = 0; i < CHANNELS; i++) div[i] <= DIV_W'(DEFAULT_DIV);
      end else begin
         running <= (mode == MODE_RUN);
         if (step_fire) step_count <= step_count + 32'd1;
         for (int i = 0; i < CHANNELS; i++) begin
            case (mode)
               MODE_RUN: begin
                  tick[i] <= term[i];
                  cnt[i]  <= term[i] ? '0 : cnt[i] + 1'b1;
               end
               MODE_STEP: begin
                  tick[i] <= step_fire;
                  cnt[i]  <= '0;
               end
               default: begin
                  // halt (and the unused encoding): count is frozen
                  tick[i] <= 1'b0;
               end
            endcase
            // a write restarts the channel but does not cancel a tick that
            // the old divisor produced on this same edge
            if (wr_hit[i]) begin
               div[i] <= cfg_divisor;
               cnt[i] <= '0;
            end
         end
      end
   end

endmodule

// File: doc/clock_controller.md
# clock_controller

Parametrised clock-enable generator for the single-cycle processor and its peripherals. It replaces the fixed 1 Hz divider with CHANNELS independently programmable tick channels, all in the `clock50MHZ` domain. It adds halt and single-step modes, where a push-button produces exactly one tick on every channel, so programs can be traced instruction by instruction on the board. Outputs are one-cycle enable pulses, never derived clocks; downstream state qualifies on `clock50MHZ` with `tick[n]`.

## Interface
Parameters:
- CHANNELS, 2: number of independent tick channels (1..8).
- DIV_W, 26: divisor and counter width.
- DEFAULT_DIV, 50000000: divisor loaded into every channel at reset.
- DEBOUNCE_CYCLES, 500000: cycles the synchronised button must stay stable (10 ms at 50 MHz); used only with CLOCK_CONTROLLER_DEBOUNCE_EN.

Ports:
- clock50MHZ  in  1  board clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  0 = halt, 1 = run, 2 = step, 3 = treated as halt.
- step_button  in  1  raw asynchronous button, active-high.
- cfg_wen  in  1  divisor write strobe, one cycle.
- cfg_channel  in  max(1,$clog2(CHANNELS))  channel addressed by the write; out-of-range writes are ignored.
- cfg_divisor  in  DIV_W  new divisor.
- tick  out  CHANNELS  per-channel one-cycle enable pulse, registered.
- running  out  1  registered; high while mode is run.
- step_count  out  32  number of steps issued; wraps 0xFFFFFFFF→0.

## Operation
- Per channel: counter `c`, divisor register `d`. Effective divisor is max(d,1), so 0 behaves as 1.
- Run: if `c` == eff−1, then `c`←0 and `tick`←1; otherwise `c`←`c`+1 and `tick`←0.
- Halt: counters freeze, `tick`←0. Leaving halt for run resumes from the frozen count.
- Step: counters are forced to 0. On a qualified button rising edge, all `tick` bits are 1 for exactly one cycle and `step_count`+1.
  - A held button yields one step only; the next step needs release and press again.
  - Edges detected while not in step mode are discarded.
- Mode changes: entering step clears all counters on the same edge. Step→run starts counting from 0.
- cfg write to channel n: `d[n]`←`cfg_divisor` and `c[n]`←0 on the same edge.
  - If that edge is also channel n's terminal count, the tick is still emitted.
  - Other channels are unaffected.
- Reset values: `tick`=0, `running`=0, `step_count`=0, all `c`=0, all `d`=DEFAULT_DIV, synchroniser and debouncer cleared to 0.
- Reset asserted mid-operation clears all outputs asynchronously. The first count happens on the first rising edge after release.

## Timing
- Run, divisor D, counter starting at 0 on an edge: `tick` is high in the cycle following the D-th edge, then periodic with period D and 1 cycle wide.
- Step latency without debounce: 2-flop synchroniser, edge detect, registered tick. `tick` is high 3 cycles after the button rises.
- Step latency with debounce: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Write latency: a write on edge k restarts the channel; its next tick follows edge k+eff.

## Configuration
- CLOCK_CONTROLLER_DEBOUNCE_EN defined: the synchronised button passes through a stability filter. The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples; shorter glitches are ignored.
- Undefined: the filter is absent and every synchronised rising edge is a step. DEBOUNCE_CYCLES is unused.

## Structure
- Package `clock_controller_pkg`:
  - mode constants MODE_HALT, MODE_RUN, MODE_STEP;
  - default parameter constants (DEFAULT_DIV, DEBOUNCE_CYCLES).
- Sub-module `button_debouncer`:
  - contains the 2-flop synchroniser, optional stability counter and rising-edge pulse output;
  - instantiated once, shared by all channels.

## Test plan
Bench settings: CHANNELS=2, DEFAULT_DIV=4, DEBOUNCE_CYCLES=8.
- Release reset with mode=run → `tick[0]` and `tick[1]` each high 1 cycle, every 4 cycles, first after edge 4; `running`=1.
- While running, write ch1 divisor=3 → `tick[1]` restarts with period 3, first after 3 edges; `tick[0]` phase unchanged.
- Write divisor 0, then 1, to ch0 → `tick[0]` high every cycle in both cases.
- Halt at `c`=2 (D=4), hold 10 cycles, return to run → no ticks while halted; next tick after 2 edges.
- Step mode, button high 100 cycles → exactly one cycle with `tick`=2'b11, 3 cycles after the rise (no-debounce build); `step_count` 0→1. Debounce build: a 5-cycle glitch gives no tick; a 20-cycle press gives one tick 11 cycles after the rise.
- Pull `reset_n` low mid-period → `tick`=0 and `step_count`=0 immediately; after release, divisors are back to 4.
